// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: issues one memory request at a time, holds the
// fetched instruction for decode, and predicts the next PC (JAL and backward
// branches taken, everything else falls through).
module fetch_ctrl #(
  parameter int                  PC_SIZE    = 32,
  parameter int                  INSTR_SIZE = 32,
  parameter logic [PC_SIZE-1:0]  RESET_PC   = PC_SIZE'(32'h8000_0000)
) (
  input  logic                  clk,
  input  logic                  rst,
  // instruction memory request
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [PC_SIZE-1:0]    imem_req_addr,
  // instruction memory response
  input  logic                  imem_rsp_valid,
  input  logic [INSTR_SIZE-1:0] imem_rsp_data,
  // execute-stage override
  input  logic                  redirect_valid,
  input  logic [PC_SIZE-1:0]    redirect_pc,
  // decode interface
  input  logic                  stall,
  output logic                  if_valid,
  output logic [INSTR_SIZE-1:0] if_instr,
  output logic [PC_SIZE-1:0]    if_pc,
  output logic                  if_pred_taken
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DROP} state_e;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  state_e                  state_q, state_d;
  logic [PC_SIZE-1:0]      pc_q, pc_d;
  logic                    ifv_q, ifv_d;
  logic [INSTR_SIZE-1:0]   instr_q, instr_d;
  logic [PC_SIZE-1:0]      ifpc_q, ifpc_d;
  logic                    pred_q, pred_d;

  logic                    accept;
  logic                    is_jal, is_bwd_br;
  logic [20:0]             jal_imm;
  logic [12:0]             br_imm;
  logic [PC_SIZE-1:0]      jal_off, br_off, next_pc;

  // Static prediction from the instruction arriving on the response bus.
  always_comb begin
    jal_imm   = {imem_rsp_data[31], imem_rsp_data[19:12], imem_rsp_data[20],
                 imem_rsp_data[30:21], 1'b0};
    br_imm    = {imem_rsp_data[31], imem_rsp_data[7], imem_rsp_data[30:25],
                 imem_rsp_data[11:8], 1'b0};
    jal_off   = PC_SIZE'(signed'(jal_imm));
    br_off    = PC_SIZE'(signed'(br_imm));
    is_jal    = (imem_rsp_data[6:0] == OP_JAL);
    is_bwd_br = (imem_rsp_data[6:0] == OP_BRANCH) && imem_rsp_data[31];
    if (is_jal)         next_pc = pc_q + jal_off;
    else if (is_bwd_br) next_pc = pc_q + br_off;
    else                next_pc = pc_q + PC_SIZE'(4);
  end

  // Request is withheld while decode holds an unconsumed instruction, so a
  // new response can never land on top of a stalled one.
  assign imem_req_valid = (state_q == S_REQ) && (!ifv_q || !stall);
  assign imem_req_addr  = pc_q;
  assign accept         = imem_req_valid && imem_req_ready;

  // Next-state, PC and decode-register update.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ifv_d   = ifv_q;
    instr_d = instr_q;
    ifpc_d  = ifpc_q;
    pred_d  = pred_q;

    if (ifv_q && !stall) ifv_d = 1'b0;

    unique case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          ifv_d   = 1'b0;
          // an accepted request now fetches a stale address: flush its reply
          state_d = accept ? S_DROP : S_REQ;
        end else if (accept) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          ifv_d   = 1'b0;
          state_d = imem_rsp_valid ? S_REQ : S_DROP;
        end else if (imem_rsp_valid) begin
          ifv_d   = 1'b1;
          instr_d = imem_rsp_data;
          ifpc_d  = pc_q;
          pred_d  = is_jal || is_bwd_br;
          pc_d    = next_pc;
          state_d = S_REQ;
        end
      end
      S_DROP: begin
        if (redirect_valid) begin
          pc_d  = redirect_pc;
          ifv_d = 1'b0;
        end
        // the outstanding reply retires here even if a redirect coincides,
        // otherwise DROP would wait for a response that never comes
        if (imem_rsp_valid) state_d = S_REQ;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      ifv_q   <= 1'b0;
      instr_q <= '0;
      ifpc_q  <= '0;
      pred_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ifv_q   <= ifv_d;
      instr_q <= instr_d;
      ifpc_q  <= ifpc_d;
      pred_q  <= pred_d;
    end
  end

  assign if_valid      = ifv_q;
  assign if_instr      = instr_q;
  assign if_pc         = ifpc_q;
  assign if_pred_taken = pred_q;

endmodule
